// File: rtl/huffman_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : huffman_decoder_pkg
// Brief    : Shared sizes and FSM encodings for the canonical Huffman
//            decoder (also used by the matching encoder).
// Revision : 1.0 - initial release
// ============================================================================
package huffman_decoder_pkg;

   localparam int NUM_SYMS = 288;          // DEFLATE literal/length alphabet
   localparam int SYM_W    = 9;            // symbol index width
   localparam int MAX_LEN  = 15;           // longest code
   localparam int LEN_W    = 4;            // code-length field, 0 = unused
   localparam int CODE_W   = MAX_LEN + 1;  // partial code / first[] width
   localparam int CNT_W    = SYM_W + 1;    // count/base/next width
   localparam int LEFT_W   = MAX_LEN + 2;  // signed Kraft remainder

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLR   = 3'd1;
   localparam logic [2:0] ST_COUNT = 3'd2;
   localparam logic [2:0] ST_OFFS  = 3'd3;
   localparam logic [2:0] ST_SORT  = 3'd4;
   localparam logic [2:0] ST_READY = 3'd5;
   localparam logic [2:0] ST_ERR   = 3'd6;

   // First canonical code of length L from the values of length L-1.
   function automatic logic [CODE_W-1:0] next_first(
      input logic [CODE_W-1:0] first_prev,
      input logic [CNT_W-1:0]  count_prev
   );
      logic [CODE_W-1:0] sum;
      sum = first_prev + CODE_W'(count_prev);
      return {sum[CODE_W-2:0], 1'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/huffman_decoder_sp_ram.sv
`default_nettype none
// ============================================================================
// Module   : huffman_decoder_sp_ram
// Brief    : Single-port RAM, synchronous write, registered read-first
//            output. The output register is cleared by reset; the array
//            itself keeps its contents.
// Revision : 1.0 - initial release
// ============================================================================
module huffman_decoder_sp_ram #(
   parameter int DEPTH  = 288,
   parameter int ADDR_W = 9,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   // storage write
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[addr] <= wdata;
      end
   end

   // registered read port; holds its value while en is low
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (en) begin
         rdata <= mem[addr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/huffman_decoder.sv
`default_nettype none
// ============================================================================
// Module   : huffman_decoder
// Brief    : Canonical Huffman decoder. Builds count/first/base tables and a
//            length-sorted symbol RAM from a per-symbol length RAM, then
//            decodes a serial MSB-first bitstream into symbols.
// Revision : 1.0 - initial release
// ============================================================================
module huffman_decoder
   import huffman_decoder_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             len_we,
   input  logic [SYM_W-1:0] len_addr,
   input  logic [LEN_W-1:0] len_data,
   input  logic             build_start,
   output logic             table_ready,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic             bit_ready,
   output logic             sym_valid,
   output logic [SYM_W-1:0] sym_data,
   input  logic             sym_ready,
   output logic             err_invalid
);

   logic [2:0]               state;
   logic [CNT_W-1:0]         cnt;      // scan index in COUNT/SORT, L in OFFS
   logic [CNT_W-1:0]         count [0:MAX_LEN];
   logic [CNT_W-1:0]         base  [0:MAX_LEN];
   logic [CNT_W-1:0]         nxt   [0:MAX_LEN];
   logic [CODE_W-1:0]        first [0:MAX_LEN];
   logic signed [LEFT_W-1:0] left;
   logic [CODE_W-1:0]        code;
   logic [LEN_W-1:0]         clen;

   logic                     lr_en, lr_we;
   logic [SYM_W-1:0]         lr_addr;
   logic [LEN_W-1:0]         lr_rdata;
   logic                     sr_en, sr_we;
   logic [SYM_W-1:0]         sr_addr, sr_wdata, sr_rdata;

   logic                     cfg, scan_rd, have_len, sort_wr, acc, match;
   logic [SYM_W-1:0]         scan_sym, rd_addr;
   logic [LEN_W-1:0]         ol, ol_m1, dlen;
   logic [CNT_W-1:0]         base_n;
   logic signed [LEFT_W-1:0] left_n;
   logic [CODE_W-1:0]        dcode, doff;

   // States in which the length RAM belongs to the host.
   assign cfg      = (state == ST_IDLE) || (state == ST_READY) || (state == ST_ERR);
   assign scan_rd  = ((state == ST_COUNT) || (state == ST_SORT)) && (cnt < CNT_W'(NUM_SYMS));
   // Read data lags the scan address by one cycle, so cnt-1 is its symbol.
   assign have_len = (cnt != '0) && (lr_rdata != '0);
   assign scan_sym = cnt[SYM_W-1:0] - SYM_W'(1);
   assign sort_wr  = (state == ST_SORT) && have_len;

   // Offset pass for length L = ol.
   assign ol     = cnt[LEN_W-1:0];
   assign ol_m1  = ol - LEN_W'(1);
   assign base_n = base[ol_m1] + count[ol_m1];
   assign left_n = (left <<< 1) - $signed(LEFT_W'(count[ol]));

   // Decode step for the incoming bit.
   assign table_ready = (state == ST_READY);
   assign bit_ready   = (state == ST_READY) && !(sym_valid && !sym_ready);
   assign acc         = bit_valid && bit_ready;
   assign dcode       = (code << 1) | CODE_W'(bit_in);
   assign dlen        = clen + LEN_W'(1);
   assign doff        = dcode - first[dlen];
   assign match       = (dcode >= first[dlen]) && (doff < CODE_W'(count[dlen]));
   assign rd_addr     = base[dlen][SYM_W-1:0] + doff[SYM_W-1:0];

   assign lr_en    = cfg ? len_we : scan_rd;
   assign lr_we    = cfg && len_we;
   assign lr_addr  = cfg ? len_addr : cnt[SYM_W-1:0];

   assign sr_en    = sort_wr || (acc && match);
   assign sr_we    = sort_wr;
   assign sr_addr  = (state == ST_SORT) ? nxt[lr_rdata][SYM_W-1:0] : rd_addr;
   assign sr_wdata = scan_sym;
   assign sym_data = sr_rdata;

   huffman_decoder_sp_ram #(
      .DEPTH (NUM_SYMS),
      .ADDR_W(SYM_W),
      .DATA_W(LEN_W)
   ) u_len_ram (
      .clk  (clk),
      .reset(reset),
      .en   (lr_en),
      .we   (lr_we),
      .addr (lr_addr),
      .wdata(len_data),
      .rdata(lr_rdata)
   );

   huffman_decoder_sp_ram #(
      .DEPTH (NUM_SYMS),
      .ADDR_W(SYM_W),
      .DATA_W(SYM_W)
   ) u_sym_ram (
      .clk  (clk),
      .reset(reset),
      .en   (sr_en),
      .we   (sr_we),
      .addr (sr_addr),
      .wdata(sr_wdata),
      .rdata(sr_rdata)
   );

   // Table build sequencing and bit-serial decode state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         left        <= '0;
         code        <= '0;
         clen        <= '0;
         err_invalid <= 1'b0;
         for (int i = 0; i <= MAX_LEN; i++) begin
            count[i] <= '0;
            base[i]  <= '0;
            nxt[i]   <= '0;
            first[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (build_start) state <= ST_CLR;
            end
            ST_CLR: begin
               for (int i = 0; i <= MAX_LEN; i++) count[i] <= '0;
               cnt         <= '0;
               left        <= LEFT_W'(1);
               code        <= '0;
               clen        <= '0;
               err_invalid <= 1'b0;
               state       <= ST_COUNT;
            end
            ST_COUNT: begin
               if (have_len) count[lr_rdata] <= count[lr_rdata] + CNT_W'(1);
               if (cnt == CNT_W'(NUM_SYMS)) begin
                  cnt   <= CNT_W'(1);
                  state <= ST_OFFS;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_OFFS: begin
               first[ol] <= next_first(first[ol_m1], count[ol_m1]);
               base[ol]  <= base_n;
               nxt[ol]   <= base_n;
               left      <= left_n;
               if (left_n[LEFT_W-1]) begin
                  err_invalid <= 1'b1;
                  state       <= ST_ERR;
               end else if (ol == LEN_W'(MAX_LEN)) begin
                  cnt   <= '0;
                  state <= ST_SORT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_SORT: begin
               if (sort_wr) nxt[lr_rdata] <= nxt[lr_rdata] + CNT_W'(1);
               if (cnt == CNT_W'(NUM_SYMS)) begin
                  state <= ST_READY;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_READY: begin
               if (build_start) begin
                  state <= ST_CLR;
               end else if (acc) begin
                  if (match) begin
                     code <= '0;
                     clen <= '0;
                  end else if (dlen == LEN_W'(MAX_LEN)) begin
                     err_invalid <= 1'b1;
                     state       <= ST_ERR;
                  end else begin
                     code <= dcode;
                     clen <= dlen;
                  end
               end
            end
            ST_ERR: begin
               if (build_start) state <= ST_CLR;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Output symbol flag: set on a matched code, cleared on handshake or rebuild.
   always_ff @(posedge clk) begin
      if (reset) begin
         sym_valid <= 1'b0;
      end else if (state == ST_CLR) begin
         sym_valid <= 1'b0;
      end else if ((state == ST_READY) && acc && match) begin
         sym_valid <= 1'b1;
      end else if (sym_ready) begin
         sym_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_huffman_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_huffman_decoder
// Brief    : Self-checking bench for huffman_decoder. Expected symbols come
//            from canonical code assignment done per symbol in the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_huffman_decoder;
   import huffman_decoder_pkg::*;

   logic             clk = 1'b0;
   logic             reset, len_we, build_start, bit_valid, bit_in, sym_ready;
   logic [SYM_W-1:0] len_addr;
   logic [LEN_W-1:0] len_data;
   logic             table_ready, bit_ready, sym_valid, err_invalid;
   logic [SYM_W-1:0] sym_data;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    lens  [NUM_SYMS];
   int    codes [NUM_SYMS];
   int    got   [$];
   int    exp_q [$];
   bit    rand_ready = 1'b0;
   string c2 [4] = '{"0", "10", "110", "111"};
   int    s2 [4] = '{1, 0, 2, 3};

   always #5 clk = ~clk;

   huffman_decoder dut (
      .clk        (clk),
      .reset      (reset),
      .len_we     (len_we),
      .len_addr   (len_addr),
      .len_data   (len_data),
      .build_start(build_start),
      .table_ready(table_ready),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .bit_ready  (bit_ready),
      .sym_valid  (sym_valid),
      .sym_data   (sym_data),
      .sym_ready  (sym_ready),
      .err_invalid(err_invalid)
   );

   // symbols handed over at the next rising edge
   always @(negedge clk) begin
      if (!reset && sym_valid && sym_ready) got.push_back(int'(sym_data));
   end

   // random consumer backpressure
   always @(posedge clk) begin
      #1;
      if (rand_ready) sym_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_lens();
      for (int s = 0; s < NUM_SYMS; s++) lens[s] = 0;
   endtask

   task automatic set_case2();
      clear_lens();
      lens[0] = 2; lens[1] = 1; lens[2] = 3; lens[3] = 3;
   endtask

   // canonical codes: shortest lengths first, ties by symbol index
   function automatic void model_codes();
      int c = 0;
      for (int l = 1; l <= MAX_LEN; l++) begin
         for (int s = 0; s < NUM_SYMS; s++) begin
            if (lens[s] == l) begin
               codes[s] = c;
               c++;
            end
         end
         c = c << 1;
      end
   endfunction

   // Kraft sum above one means the table is oversubscribed
   function automatic bit model_oversub();
      longint k = 0;
      for (int s = 0; s < NUM_SYMS; s++)
         if (lens[s] != 0) k += longint'(1) << (MAX_LEN - lens[s]);
      return k > (longint'(1) << MAX_LEN);
   endfunction

   task automatic load_lens();
      for (int s = 0; s < NUM_SYMS; s++) begin
         len_we   = 1'b1;
         len_addr = SYM_W'(s);
         len_data = LEN_W'(lens[s]);
         tick();
      end
      len_we = 1'b0;
      model_codes();
   endtask

   task automatic build(output int cyc);
      build_start = 1'b1;
      tick();
      build_start = 1'b0;
      tick();
      tick();
      cyc = 3;
      while (!table_ready && !err_invalid && cyc < 1000) begin
         tick();
         cyc++;
      end
   endtask

   task automatic send_bit(input logic b);
      int guard = 0;
      bit_valid = 1'b1;
      bit_in    = b;
      @(negedge clk);
      while (!bit_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!bit_ready) check("bit_accept_timeout", bit_ready, 1);
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_bit(s[i] == "1");
   endtask

   task automatic send_sym(input int sym);
      for (int i = lens[sym] - 1; i >= 0; i--) send_bit(codes[sym][i]);
   endtask

   task automatic compare_syms(input string tag);
      rand_ready = 1'b0;
      sym_ready  = 1'b1;
      repeat (10) tick();
      check({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(tag, got[i], exp_q[i]);
      got.delete();
      exp_q.delete();
   endtask

   // 15 bits that cannot form a valid code; first one is a 1
   task automatic err_stream(input string tag);
      got.delete();
      for (int i = 0; i < MAX_LEN - 1; i++) send_bit((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      check({tag, "_err_before"}, err_invalid, 0);
      check({tag, "_ready_before"}, bit_ready, 1);
      send_bit(1'($urandom_range(0, 1)));
      check({tag, "_err"}, err_invalid, 1);
      check({tag, "_bit_ready"}, bit_ready, 0);
      check({tag, "_table_ready"}, table_ready, 0);
      repeat (3) tick();
      check({tag, "_no_sym"}, got.size(), 0);
   endtask

   initial begin
      int cyc;
      reset = 1'b1; len_we = 1'b0; len_addr = '0; len_data = '0;
      build_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_table_ready", table_ready, 0);
      check("rst_bit_ready", bit_ready, 0);
      check("rst_sym_valid", sym_valid, 0);
      check("rst_err", err_invalid, 0);
      check("rst_sym_data", sym_data, 0);

      // fixed DEFLATE literal/length table
      for (int s = 0; s < NUM_SYMS; s++)
         lens[s] = (s < 144) ? 8 : (s < 256) ? 9 : (s < 280) ? 7 : 8;
      load_lens();
      build(cyc);
      check("t1_table_ready", table_ready, 1);
      check("t1_build_cycles_ok", cyc <= 2 * NUM_SYMS + MAX_LEN + 6, 1);
      got.delete();
      send_str("00110000");
      check("t1_sym0", sym_data, 0);
      send_str("0000000");
      check("t1_sym256", sym_data, 256);
      send_str("110010000");
      check("t1_sym144", sym_data, 144);
      exp_q = '{0, 256, 144};
      compare_syms("t1_stream");

      // small table, one symbol per code, one-cycle latency
      set_case2();
      load_lens();
      build(cyc);
      check("t2_table_ready", table_ready, 1);
      for (int k = 0; k < 4; k++) begin
         send_str(c2[k]);
         check("t2_lat_valid", sym_valid, 1);
         check("t2_lat_data", sym_data, s2[k]);
         exp_q.push_back(s2[k]);
      end
      compare_syms("t2_stream");

      // consumer stall after the first symbol
      sym_ready = 1'b0;
      send_bit(1'b0);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t3_bit_ready_low", bit_ready, 0);
         check("t3_sym_valid_held", sym_valid, 1);
         check("t3_sym_data_held", sym_data, 1);
      end
      tick();
      bit_valid = 1'b0;
      sym_ready = 1'b1;
      send_str("10");
      send_str("110");
      send_str("111");
      exp_q = '{1, 0, 2, 3};
      compare_syms("t3_stream");

      // oversubscribed table
      clear_lens();
      lens[0] = 1; lens[1] = 1; lens[2] = 1;
      load_lens();
      build(cyc);
      check("t4_err", err_invalid, 1);
      check("t4_table_ready", table_ready, 0);
      check("t4_bit_ready", bit_ready, 0);

      // single one-bit code, everything else undecodable
      clear_lens();
      lens[5] = 1;
      load_lens();
      build(cyc);
      check("t5_table_ready", table_ready, 1);
      check("t5_err_clear", err_invalid, 0);
      got.delete();
      send_bit(1'b0);
      check("t5_sym5", sym_data, 5);
      repeat (2) tick();
      check("t5_sym5_count", got.size(), 1);
      err_stream("t5");

      // all-zero lengths build fine but decode nothing
      clear_lens();
      load_lens();
      build(cyc);
      check("t5z_table_ready", table_ready, 1);
      err_stream("t5z");

      // random tables and random symbol streams with backpressure
      for (int it = 0; it < 6; it++) begin
         int nsym, lo, hi, s;
         bit over;
         int used[$];
         used.delete();
         clear_lens();
         nsym = $urandom_range(2, 20);
         lo = (it % 2 == 0) ? 5 : 1;
         hi = (it % 2 == 0) ? 12 : 6;
         for (int k = 0; k < nsym; k++) lens[$urandom_range(0, NUM_SYMS - 1)] = $urandom_range(lo, hi);
         load_lens();
         build(cyc);
         over = model_oversub();
         check("rnd_err", err_invalid, over);
         check("rnd_table_ready", table_ready, !over);
         if (!over) begin
            for (int q = 0; q < NUM_SYMS; q++) if (lens[q] != 0) used.push_back(q);
            got.delete();
            rand_ready = 1'b1;
            for (int k = 0; k < 40; k++) begin
               s = used[$urandom_range(0, used.size() - 1)];
               exp_q.push_back(s);
               if ($urandom_range(0, 3) == 0) tick();
               send_sym(s);
            end
            compare_syms("rnd_sym");
         end
      end

      // reset during SORT, then abort a partial code with a rebuild
      set_case2();
      load_lens();
      build_start = 1'b1;
      tick();
      build_start = 1'b0;
      repeat (400) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_table_ready", table_ready, 0);
      check("t6_bit_ready", bit_ready, 0);
      check("t6_sym_valid", sym_valid, 0);
      check("t6_err", err_invalid, 0);
      check("t6_sym_data", sym_data, 0);
      build(cyc);
      check("t6_rebuild_ready", table_ready, 1);
      got.delete();
      send_str("11");
      build(cyc);
      check("t6_abort_ready", table_ready, 1);
      for (int k = 0; k < 4; k++) begin
         send_str(c2[k]);
         exp_q.push_back(s2[k]);
      end
      compare_syms("t6_stream");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
